// File: rtl/shift_exec_stage_pkg.sv
// Shared opcode encodings, FSM states and widths for the shift execute stage.
package shift_exec_stage_pkg;

    localparam int unsigned SHAMT_W = 6;
    localparam int unsigned OP_W    = 3;

    localparam logic [OP_W-1:0] OP_SLL  = 3'b000;
    localparam logic [OP_W-1:0] OP_SRL  = 3'b001;
    localparam logic [OP_W-1:0] OP_SRA  = 3'b010;
    localparam logic [OP_W-1:0] OP_SLLW = 3'b100;
    localparam logic [OP_W-1:0] OP_SRLW = 3'b101;
    localparam logic [OP_W-1:0] OP_SRAW = 3'b110;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/shift_exec_stage_shift_core.sv
// Combinational shifter: 64-bit SLL/SRL/SRA and the 32-bit sign-extended W forms.
module shift_exec_stage_shift_core
    import shift_exec_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [OP_W-1:0]       op,
    input  logic [DATA_WIDTH-1:0] num_a,
    input  logic [DATA_WIDTH-1:0] num_b,
    output logic [DATA_WIDTH-1:0] result_c,
    output logic                  illegal_c
);

    localparam int unsigned SH_W   = $clog2(DATA_WIDTH);
    localparam int unsigned HALF_W = DATA_WIDTH / 2;

    logic [SH_W-1:0]   amt;
    logic [SH_W-2:0]   amt_w;
    logic [HALF_W-1:0] lo;
    logic [HALF_W-1:0] w_res;
    logic              unused_hi_b;

    assign amt         = num_b[SH_W-1:0];
    assign amt_w       = num_b[SH_W-2:0];
    assign lo          = num_a[HALF_W-1:0];
    assign unused_hi_b = ^num_b[DATA_WIDTH-1:SH_W];

    always_comb begin
        result_c  = '0;
        illegal_c = 1'b0;
        w_res     = '0;
        unique case (op)
            OP_SLL:  result_c = num_a << amt;
            OP_SRL:  result_c = num_a >> amt;
            OP_SRA:  result_c = DATA_WIDTH'($signed(num_a) >>> amt);
            OP_SLLW: w_res    = lo << amt_w;
            OP_SRLW: w_res    = lo >> amt_w;
            OP_SRAW: w_res    = HALF_W'($signed(lo) >>> amt_w);
            default: illegal_c = 1'b1;
        endcase
        // W forms always sign-extend bit 31 of the 32-bit result
        if (op[2] && !illegal_c) begin
            result_c = {{(DATA_WIDTH - HALF_W){w_res[HALF_W-1]}}, w_res};
        end
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Registered shift execute stage: 1-cycle latency with a 2-entry output/skid buffer.
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_W      = 5
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_flush,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [OP_W-1:0]       in_op,
    input  logic [DATA_WIDTH-1:0] in_numA,
    input  logic [DATA_WIDTH-1:0] in_numB,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_illegal
);

    state_e                state_q, state_d;
    logic                  out_ready_q, out_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0]      out_tag_q, out_tag_d;
    logic                  out_illegal_q, out_illegal_d;
    logic [DATA_WIDTH-1:0] skid_result_q, skid_result_d;
    logic [TAG_W-1:0]      skid_tag_q, skid_tag_d;
    logic                  skid_illegal_q, skid_illegal_d;

    logic [DATA_WIDTH-1:0] core_result_c;
    logic                  core_illegal_c;
    logic                  accept_c;
    logic                  retire_c;

    shift_exec_stage_shift_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .op        (in_op),
        .num_a     (in_numA),
        .num_b     (in_numB),
        .result_c  (core_result_c),
        .illegal_c (core_illegal_c)
    );

    assign accept_c = in_valid & out_ready_q;
    assign retire_c = out_valid_q & in_ready;

    always_comb begin
        state_d        = state_q;
        out_result_d   = out_result_q;
        out_tag_d      = out_tag_q;
        out_illegal_d  = out_illegal_q;
        skid_result_d  = skid_result_q;
        skid_tag_d     = skid_tag_q;
        skid_illegal_d = skid_illegal_q;

        // Flush drops everything, including an op offered this cycle
        if (in_flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        out_result_d  = core_result_c;
                        out_tag_d     = in_tag;
                        out_illegal_d = core_illegal_c;
                        state_d       = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_c && retire_c) begin
                        out_result_d  = core_result_c;
                        out_tag_d     = in_tag;
                        out_illegal_d = core_illegal_c;
                    end else if (accept_c) begin
                        skid_result_d  = core_result_c;
                        skid_tag_d     = in_tag;
                        skid_illegal_d = core_illegal_c;
                        state_d        = ST_TWO;
                    end else if (retire_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (retire_c) begin
                        out_result_d  = skid_result_q;
                        out_tag_d     = skid_tag_q;
                        out_illegal_d = skid_illegal_q;
                        state_d       = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        out_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q        <= ST_EMPTY;
            out_ready_q    <= 1'b1;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_tag_q      <= '0;
            out_illegal_q  <= 1'b0;
            skid_result_q  <= '0;
            skid_tag_q     <= '0;
            skid_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_ready_q    <= out_ready_d;
            out_valid_q    <= out_valid_d;
            out_result_q   <= out_result_d;
            out_tag_q      <= out_tag_d;
            out_illegal_q  <= out_illegal_d;
            skid_result_q  <= skid_result_d;
            skid_tag_q     <= skid_tag_d;
            skid_illegal_q <= skid_illegal_d;
        end
    end

    assign out_ready   = out_ready_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: directed cases plus randomized traffic vs. an arithmetic model.
module tb_shift_exec_stage;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  in_op;
    logic [63:0] num_a;
    logic [63:0] num_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        in_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    shift_exec_stage #(.DATA_WIDTH(64), .TAG_W(5)) dut (
        .in_clk      (clk),
        .in_rst_n    (rst_n),
        .in_flush    (flush),
        .in_valid    (in_valid),
        .out_ready   (out_ready),
        .in_op       (in_op),
        .in_numA     (num_a),
        .in_numB     (num_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .in_ready    (in_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    // Reference: shifts expressed as multiply/divide by powers of two.
    function automatic exp_t model(input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input logic [4:0] tag);
        exp_t        e;
        logic [63:0] p64;
        logic [31:0] p32;
        logic [31:0] a32;
        logic [31:0] r32;
        p64   = 64'd1 << (b % 64);
        p32   = 32'd1 << (b % 32);
        a32   = a[31:0];
        r32   = '0;
        e.tag = tag;
        e.ill = 1'b0;
        e.res = '0;
        case (op)
            3'd0: e.res = a * p64;
            3'd1: e.res = a / p64;
            3'd2: e.res = a[63] ? ~((~a) / p64) : a / p64;
            3'd4: r32 = a32 * p32;
            3'd5: r32 = a32 / p32;
            3'd6: r32 = a32[31] ? ~((~a32) / p32) : a32 / p32;
            default: e.ill = 1'b1;
        endcase
        if (op == 3'd4 || op == 3'd5 || op == 3'd6)
            e.res = 64'($signed(r32));
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, record the accept the next edge will see.
    task automatic drive_cycle(input logic v, input logic [2:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] tag,
                               input logic fl, input logic rdy, output logic acc);
        in_valid = v;
        in_op    = op;
        num_a    = a;
        num_b    = b;
        in_tag   = tag;
        flush    = fl;
        in_ready = rdy;
        acc      = v && out_ready && !fl && rst_n;
        if (fl || !rst_n) sb_q.delete();
        if (acc) sb_q.push_back(model(op, a, b, tag));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 3'd0, '0, '0, '0, 1'b0, rdy, acc);
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input logic rdy);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) drive_cycle(1'b1, op, a, b, tag, 1'b0, rdy, acc);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: tag %0d never accepted", tag);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_ready"}, 64'(out_ready), 64'd1);
        chk({nm, "_result"}, out_result, 64'd0);
        chk({nm, "_tag"}, 64'(out_tag), 64'd0);
        chk({nm, "_illegal"}, 64'(out_illegal), 64'd0);
    endtask

    // Monitor: every retire is checked against the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !flush && out_valid && in_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: tag %0d result 0x%h with nothing expected",
                             out_tag, out_result);
                end else begin
                    e = sb_q.pop_front();
                    if (out_result !== e.res || out_tag !== e.tag || out_illegal !== e.ill) begin
                        n_bad++;
                        $display("FAIL retire: got res 0x%h tag %0d ill %0b expected res 0x%h tag %0d ill %0b",
                                 out_result, out_tag, out_illegal, e.res, e.tag, e.ill);
                    end
                end
            end
        end
    end

    initial begin
        logic acc;
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        num_a    = '0;
        num_b    = '0;
        in_tag   = '0;
        in_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Directed single ops, including boundaries
        issue(3'b000, 64'h1, 64'h3F, 5'd7, 1'b1);
        chk("sll63_direct", out_result, 64'h8000_0000_0000_0000);
        chk("sll63_tag", 64'(out_tag), 64'd7);
        idle(1, 1'b1);
        issue(3'b010, 64'h8000_0000_0000_0000, 64'd4, 5'd1, 1'b1);
        issue(3'b001, 64'h8000_0000_0000_0000, 64'd4, 5'd2, 1'b1);
        issue(3'b110, 64'h0000_0000_8000_0000, 64'h21, 5'd3, 1'b1);
        issue(3'b100, 64'h1, 64'd31, 5'd4, 1'b1);
        issue(3'b010, 64'h8000_0000_0000_1234, 64'd63, 5'd5, 1'b1);
        issue(3'b000, 64'h0123_4567_89AB_CDEF, 64'd64, 5'd6, 1'b1);
        issue(3'b101, 64'hDEAD_BEEF_8765_4321, 64'd0, 5'd8, 1'b1);
        issue(3'b011, 64'hFFFF, 64'd1, 5'd9, 1'b1);
        chk("illegal_flag", 64'(out_illegal), 64'd1);
        chk("illegal_result", out_result, 64'd0);
        issue(3'b111, 64'hFFFF, 64'd1, 5'd10, 1'b1);
        idle(2, 1'b1);

        // Backpressure: two accepts fill the stage, third waits
        issue(3'b000, 64'd1, 64'd1, 5'd1, 1'b0);
        issue(3'b000, 64'd2, 64'd1, 5'd2, 1'b0);
        chk("bp_ready_low", 64'(out_ready), 64'd0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 3'd0, 64'd3, 64'd1, 5'd3, 1'b0, 1'b0, acc);
        chk("bp_no_accept", 64'(acc), 64'd0);
        issue(3'b000, 64'd3, 64'd1, 5'd3, 1'b1);
        idle(4, 1'b1);

        // Flush while full, with a valid op offered
        issue(3'b001, 64'hF0, 64'd4, 5'd11, 1'b0);
        issue(3'b001, 64'hF00, 64'd4, 5'd12, 1'b0);
        drive_cycle(1'b1, 3'd0, 64'd5, 64'd0, 5'd13, 1'b1, 1'b0, acc);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(out_ready), 64'd1);
        idle(3, 1'b1);

        // Reset while full
        issue(3'b000, 64'hAA, 64'd3, 5'd14, 1'b0);
        issue(3'b000, 64'hBB, 64'd3, 5'd15, 1'b0);
        rst_n = 1'b0;
        drive_cycle(1'b1, 3'd0, 64'd5, 64'd0, 5'd16, 1'b1, 1'b1, acc);
        chk_reset_vals("midreset");
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom % 5)
                0: b = 64'($urandom_range(0, 1)) * 63;
                1: b = 64'($urandom_range(0, 2)) * 32;
                default: ;
            endcase
            drive_cycle(($urandom % 4) != 0, 3'($urandom), a, b, 5'($urandom),
                        ($urandom % 60) == 0, ($urandom % 3) != 0, acc);
        end

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1, 1'b1);
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        idle(1, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
